id_ex_stage: RTL and testbench

ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the 5-stage MIPS pipeline. It sits directly upstream of the ALU-with-control block and supplies `data1`, `data2`, the 6-bit funct field, and `ALUOp1`/`ALUOp2` on every cycle. It also raises the stall used to freeze PC and IF/ID, and converts flushes and stalls into bubbles.

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/forward_unit.sv | 25 ++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared ID/EX definitions: control-bit positions, forward-select codes, ALUOp encodings.
package id_ex_stage_pkg;

  // Bit positions inside the 9-bit decoded control word.
  localparam int unsigned CTRL_W         = 9;
  localparam int unsigned CTRL_REG_WRITE = 8;
  localparam int unsigned CTRL_MEM_TO_REG = 7;
  localparam int unsigned CTRL_MEM_READ  = 6;
  localparam int unsigned CTRL_MEM_WRITE = 5;
  localparam int unsigned CTRL_BRANCH    = 4;
  localparam int unsigned CTRL_ALU_SRC   = 3;
  localparam int unsigned CTRL_REG_DST   = 2;
  localparam int unsigned CTRL_ALU_OP1   = 1;
  localparam int unsigned CTRL_ALU_OP2   = 0;

  // Width of the control slice handed on to EX/MEM.
  localparam int unsigned EX_CTRL_W = 5;

  // Operand source selected by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // {alu_op1, alu_op2} encodings shared with the ALU control block.
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one source register index.
module forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  output fwd_sel_e      sel
);

  // Youngest producer wins; register 0 is hardwired and never forwarded.
  always_comb begin
    sel = FWD_REG;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RW-1:0]        id_rs,
  input  logic [RW-1:0]        id_rt,
  input  logic [RW-1:0]        id_rd,
  input  logic [DW-1:0]        id_rdata1,
  input  logic [DW-1:0]        id_rdata2,
  input  logic [DW-1:0]        id_imm,
  input  logic [5:0]           id_funct,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 flush,
  input  logic                 exmem_reg_write,
  input  logic [RW-1:0]        exmem_rd,
  input  logic [DW-1:0]        exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [RW-1:0]        memwb_rd,
  input  logic [DW-1:0]        memwb_result,
  output logic                 stall,
  output logic [DW-1:0]        ex_data1,
  output logic [DW-1:0]        ex_data2,
  output logic [5:0]           ex_funct,
  output logic                 ex_alu_op1,
  output logic                 ex_alu_op2,
  output logic [DW-1:0]        ex_store_data,
  output logic [RW-1:0]        ex_write_reg,
  output logic [EX_CTRL_W-1:0] ex_ctrl
);

  logic [RW-1:0]     ex_rs_q, ex_rt_q, ex_rd_q;
  logic [DW-1:0]     ex_rdata1_q, ex_rdata2_q, ex_imm_q;
  logic [5:0]        ex_funct_q;
  logic [CTRL_W-1:0] ex_ctrl_q;

  logic              load_bubble;
  fwd_sel_e          sel_a, sel_b;
  logic [DW-1:0]     fwd_a, fwd_b;

  // Load in EX whose destination feeds the instruction now in ID.
  always_comb begin
    stall = ex_ctrl_q[CTRL_MEM_READ] && (ex_rt_q != '0) &&
            ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    load_bubble = flush || stall;
  end

  // ID/EX register; a killed or stalled slot becomes an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_funct_q  <= '0;
      ex_ctrl_q   <= '0;
    end else if (load_bubble) begin
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rd_q     <= '0;
      ex_rdata1_q <= '0;
      ex_rdata2_q <= '0;
      ex_imm_q    <= '0;
      ex_funct_q  <= '0;
      ex_ctrl_q   <= '0;
    end else begin
      ex_rs_q     <= id_rs;
      ex_rt_q     <= id_rt;
      ex_rd_q     <= id_rd;
      ex_rdata1_q <= id_rdata1;
      ex_rdata2_q <= id_rdata2;
      ex_imm_q    <= id_imm;
      ex_funct_q  <= id_funct;
      ex_ctrl_q   <= id_ctrl;
    end
  end

  forward_unit #(
    .RW(RW)
  ) u_fwd_a (
    .idx             (ex_rs_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (sel_a)
  );

  forward_unit #(
    .RW(RW)
  ) u_fwd_b (
    .idx             (ex_rt_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (sel_b)
  );

  // Operand muxes driven by the forwarding selects.
  always_comb begin
    fwd_a = ex_rdata1_q;
    fwd_b = ex_rdata2_q;
    case (sel_a)
      FWD_EXMEM: fwd_a = exmem_result;
      FWD_MEMWB: fwd_a = memwb_result;
      default:   fwd_a = ex_rdata1_q;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = exmem_result;
      FWD_MEMWB: fwd_b = memwb_result;
      default:   fwd_b = ex_rdata2_q;
    endcase
  end

  // EX-stage outputs derived from the registered slot.
  always_comb begin
    ex_data1      = fwd_a;
    ex_store_data = fwd_b;
    ex_data2      = ex_ctrl_q[CTRL_ALU_SRC] ? ex_imm_q : fwd_b;
    ex_write_reg  = ex_ctrl_q[CTRL_REG_DST] ? ex_rd_q : ex_rt_q;
    ex_funct      = ex_funct_q;
    ex_alu_op1    = ex_ctrl_q[CTRL_ALU_OP1];
    ex_alu_op2    = ex_ctrl_q[CTRL_ALU_OP2];
    ex_ctrl       = ex_ctrl_q[CTRL_REG_WRITE:CTRL_BRANCH];
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX outputs queued at drive time, checked after.
module tb_id_ex_stage;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [31:0] r1, r2, imm;
    logic [5:0]  funct;
    logic [8:0]  ctrl;
  } instr_t;

  typedef struct packed {
    logic [31:0] d1, d2, sd;
    logic [5:0]  funct;
    logic        a1, a2;
    logic [4:0]  wreg;
    logic [4:0]  ctrl;
  } exp_t;

  // Control words: {rw, m2r, mr, mw, br, alu_src, reg_dst, op1, op2}
  localparam logic [8:0] C_RTYPE = 9'b1_0_0_0_0_0_1_1_0;
  localparam logic [8:0] C_LW    = 9'b1_1_1_0_0_1_0_0_0;
  localparam logic [8:0] C_ADDI  = 9'b1_0_0_0_0_1_0_0_0;
  localparam logic [8:0] C_SW    = 9'b0_0_0_1_0_1_0_0_0;

  logic        clk, rst_n;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm;
  logic [5:0]  id_funct;
  logic [8:0]  id_ctrl;
  logic        flush;
  logic        exm_wr, mwb_wr;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_res, mwb_res;
  logic        stall;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [5:0]  ex_funct;
  logic        ex_alu_op1, ex_alu_op2;
  logic [4:0]  ex_write_reg;
  logic [4:0]  ex_ctrl;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   exp_q[$];
  instr_t cur;      // model of the instruction held in EX
  instr_t bubble;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_rdata1       (id_rdata1),
    .id_rdata2       (id_rdata2),
    .id_imm          (id_imm),
    .id_funct        (id_funct),
    .id_ctrl         (id_ctrl),
    .flush           (flush),
    .exmem_reg_write (exm_wr),
    .exmem_rd        (exm_rd),
    .exmem_result    (exm_res),
    .memwb_reg_write (mwb_wr),
    .memwb_rd        (mwb_rd),
    .memwb_result    (mwb_res),
    .stall           (stall),
    .ex_data1        (ex_data1),
    .ex_data2        (ex_data2),
    .ex_funct        (ex_funct),
    .ex_alu_op1      (ex_alu_op1),
    .ex_alu_op2      (ex_alu_op2),
    .ex_store_data   (ex_store_data),
    .ex_write_reg    (ex_write_reg),
    .ex_ctrl         (ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rv);
    if (exm_wr && exm_rd != 5'd0 && exm_rd == idx) return exm_res;
    if (mwb_wr && mwb_rd != 5'd0 && mwb_rd == idx) return mwb_res;
    return rv;
  endfunction

  function automatic exp_t model(input instr_t i);
    exp_t e;
    e.d1    = fwd(i.rs, i.r1);
    e.sd    = fwd(i.rt, i.r2);
    e.d2    = i.ctrl[3] ? i.imm : e.sd;
    e.funct = i.funct;
    e.a1    = i.ctrl[1];
    e.a2    = i.ctrl[0];
    e.wreg  = i.ctrl[2] ? i.rd : i.rt;
    e.ctrl  = i.ctrl[8:4];
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_data1"}, ex_data1, e.d1);
    check_eq({tag, "_data2"}, ex_data2, e.d2);
    check_eq({tag, "_store"}, ex_store_data, e.sd);
    check_eq({tag, "_funct"}, {26'd0, ex_funct}, {26'd0, e.funct});
    check_eq({tag, "_aop"}, {30'd0, ex_alu_op1, ex_alu_op2}, {30'd0, e.a1, e.a2});
    check_eq({tag, "_wreg"}, {27'd0, ex_write_reg}, {27'd0, e.wreg});
    check_eq({tag, "_ctrl"}, {27'd0, ex_ctrl}, {27'd0, e.ctrl});
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mr, input logic [31:0] mres);
    exm_wr = ew; exm_rd = er; exm_res = eres;
    mwb_wr = mw; mwb_rd = mr; mwb_res = mres;
  endtask

  // One pipeline cycle: present i in ID, check stall, clock it into EX and check outputs.
  task automatic step(input string tag, input instr_t i, input logic fl);
    logic exp_stall;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_rdata1 = i.r1; id_rdata2 = i.r2; id_imm = i.imm;
    id_funct = i.funct; id_ctrl = i.ctrl; flush = fl;
    #1;
    exp_stall = cur.ctrl[6] && cur.rt != 5'd0 && (cur.rt == i.rs || cur.rt == i.rt);
    check_eq({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
    cur = (fl || exp_stall) ? bubble : i;
    exp_q.push_back(model(cur));
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Re-evaluate the combinational outputs after forwarding inputs change.
  task automatic settle(input string tag);
    exp_q.push_back(model(cur));
    #1;
    pop_check(tag);
  endtask

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [5:0] fn,
                                input logic [8:0] c);
    instr_t i;
    i.rs = rs; i.rt = rt; i.rd = rd; i.r1 = r1; i.r2 = r2;
    i.imm = imm; i.funct = fn; i.ctrl = c;
    return i;
  endfunction

  initial begin
    instr_t ri;
    bubble = '0;
    cur    = '0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_rdata1 = '0; id_rdata2 = '0;
    id_imm = '0; id_funct = '0; id_ctrl = '0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    #3;
    check_eq("rst0_stall", {31'd0, stall}, 32'd0);
    settle("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain pass-through: add $rd,$1,$2
    step("plain", mk(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h1234, 6'h20, C_RTYPE), 1'b0);

    // Immediate operand selection
    step("addi", mk(5'd6, 5'd7, 5'd0, 32'h11, 32'h22, 32'hFFFF_FFF0, 6'h30, C_ADDI), 1'b0);

    // Forward priority on operand A
    step("fwd_ld", mk(5'd3, 5'd9, 5'd10, 32'h01, 32'h02, 32'd0, 6'h20, C_RTYPE), 1'b0);
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    settle("fwd_exmem");
    check_eq("fwd_exmem_direct", ex_data1, 32'hAA);
    set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    settle("fwd_memwb");
    check_eq("fwd_memwb_direct", ex_data1, 32'hBB);
    // Operand B forwarding into the store-data path
    set_fwd(1'b1, 5'd9, 32'hCC, 1'b0, 5'd0, 32'd0);
    settle("fwd_b");
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Register 0 is never forwarded
    set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    step("r0", mk(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 6'h20, C_RTYPE), 1'b0);
    check_eq("r0_direct", ex_data1, 32'd0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Load-use: lw $4, then consumer of $4 stalls once, then proceeds
    step("lw", mk(5'd8, 5'd4, 5'd0, 32'h100, 32'h0, 32'h8, 6'h00, C_LW), 1'b0);
    step("lu_stall", mk(5'd4, 5'd5, 5'd6, 32'h3, 32'h4, 32'd0, 6'h22, C_RTYPE), 1'b0);
    check_eq("lu_bubble_ctrl", {27'd0, ex_ctrl}, 32'd0);
    step("lu_go", mk(5'd4, 5'd5, 5'd6, 32'h3, 32'h4, 32'd0, 6'h22, C_RTYPE), 1'b0);

    // Flush alone
    step("flush", mk(5'd1, 5'd2, 5'd3, 32'h9, 32'hA, 32'd0, 6'h24, C_RTYPE), 1'b1);
    check_eq("flush_funct", {26'd0, ex_funct}, 32'd0);

    // Flush together with a load-use stall
    step("lw2", mk(5'd1, 5'd7, 5'd0, 32'h40, 32'h0, 32'h4, 6'h00, C_LW), 1'b0);
    step("fl_st", mk(5'd2, 5'd7, 5'd8, 32'h1, 32'h2, 32'd0, 6'h25, C_RTYPE), 1'b1);
    check_eq("fl_st_ctrl", {27'd0, ex_ctrl}, 32'd0);

    // Randomised stream with random forwarding sources
    for (int k = 0; k < 40; k++) begin
      ri = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom, $urandom, $urandom, 6'($urandom), 9'($urandom));
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      step("rand", ri, 1'($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-run with a live instruction in EX
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step("pre_rst", mk(5'd1, 5'd2, 5'd3, 32'h77, 32'h88, 32'h99, 6'h2A, C_SW), 1'b0);
    rst_n = 1'b0;
    cur   = bubble;
    settle("mid_rst");
    check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // First edge after reset captures normally
    step("post_rst", mk(5'd2, 5'd3, 5'd4, 32'h12, 32'h34, 32'h56, 6'h20, C_RTYPE), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
